uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the existing transmitter and its BaudRateGen.
- Samples the serial line at 16x oversampling and reassembles 8-bit LSB-first frames with optional parity.
- Presents each frame to the host side as a one-cycle valid pulse with parity and framing error flags.
- Sits between the pad-side RxIn and the system bus.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx_tick_gen.sv | 49 ++++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, baud-select encoding and
// the oversample divisor constants used by both the receiver and the
// transmitter's baud generator.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIV_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rxState_t;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baudSel_t;

  function automatic int unsigned baudRate(baudSel_t sel);
    case (sel)
      BAUD_2400:  return 2400;
      BAUD_4800:  return 4800;
      BAUD_9600:  return 9600;
      default:    return 19200;
    endcase
  endfunction

  // Clocks per oversample tick, rounded to nearest.
  function automatic logic [DIV_WIDTH-1:0] baudDivisor(baudSel_t sel, int unsigned clkFreq);
    int unsigned ticksPerSec;
    ticksPerSec = baudRate(sel) * OVERSAMPLE;
    return DIV_WIDTH'((clkFreq + ticksPerSec / 2) / ticksPerSec);
  endfunction

  localparam logic [DIV_WIDTH-1:0] DIV_2400  = baudDivisor(BAUD_2400,  CLK_FREQ);
  localparam logic [DIV_WIDTH-1:0] DIV_4800  = baudDivisor(BAUD_4800,  CLK_FREQ);
  localparam logic [DIV_WIDTH-1:0] DIV_9600  = baudDivisor(BAUD_9600,  CLK_FREQ);
  localparam logic [DIV_WIDTH-1:0] DIV_19200 = baudDivisor(BAUD_19200, CLK_FREQ);

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: line configuration and serial input
// in, received byte and status out.
//
// Handshake: DataValid is a one-cycle strobe with no backpressure. The host
// takes DataOut, ParityError and FramingError in the cycle DataValid is high;
// those three keep their values until the next DataValid, so a late read
// still sees the last frame.
interface uart_rx_if;
  import uart_pkg::*;

  logic [1:0]           BaudRate;
  logic                 ParityEn;
  logic                 ParityOdd;
  logic                 RxIn;
  logic [DATA_BITS-1:0] DataOut;
  logic                 DataValid;
  logic                 ParityError;
  logic                 FramingError;
  logic                 Busy;

  modport master (
    input  BaudRate, ParityEn, ParityOdd, RxIn,
    output DataOut, DataValid, ParityError, FramingError, Busy
  );

  modport slave (
    output BaudRate, ParityEn, ParityOdd, RxIn,
    input  DataOut, DataValid, ParityError, FramingError, Busy
  );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: divides the system clock down to 16x the
// selected baud rate. A restart strobe re-phases the divider so the first
// tick lands a full divisor after the start edge.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = uart_pkg::CLK_FREQ
) (
  input  logic     Clock,
  input  logic     Reset,
  input  baudSel_t baudSel,
  input  logic     restart,
  output logic     tick
);

  localparam logic [DIV_WIDTH-1:0] MAX_2400  = baudDivisor(BAUD_2400,  CLK_FREQ) - 16'd1;
  localparam logic [DIV_WIDTH-1:0] MAX_4800  = baudDivisor(BAUD_4800,  CLK_FREQ) - 16'd1;
  localparam logic [DIV_WIDTH-1:0] MAX_9600  = baudDivisor(BAUD_9600,  CLK_FREQ) - 16'd1;
  localparam logic [DIV_WIDTH-1:0] MAX_19200 = baudDivisor(BAUD_19200, CLK_FREQ) - 16'd1;

  logic [DIV_WIDTH-1:0] divCnt;
  logic [DIV_WIDTH-1:0] divMax;

  // Terminal count for the selected baud rate.
  always_comb begin
    divMax = MAX_2400;
    case (baudSel)
      BAUD_2400:  divMax = MAX_2400;
      BAUD_4800:  divMax = MAX_4800;
      BAUD_9600:  divMax = MAX_9600;
      BAUD_19200: divMax = MAX_19200;
      default:    divMax = MAX_2400;
    endcase
  end

  // Free-running divider, cleared by restart and wrapping at the terminal count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      divCnt <= '0;
    end else if (restart || divCnt == divMax) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  assign tick = (divCnt == divMax) && !restart;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised line, 16x oversampling, 8-bit LSB-first
// frames with optional parity. Each frame is delivered as a one-cycle
// DataValid with parity and framing flags, even when a flag is set.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = uart_pkg::CLK_FREQ
) (
  input  logic     Clock,
  input  logic     Reset,
  uart_rx_if.master bus,
  output rxState_t StateDbg
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rxState_t state, stateNext;

  logic rxMeta, rxSync, rxPrev;
  logic startEdge;
  logic tick, midTick, fullTick;
  logic restart, frameDone;

  baudSel_t baudL;
  logic     parityEnL, parityOddL;

  logic [TICK_W-1:0]    tickCnt;
  logic [BIT_W-1:0]     bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parityErr;

  logic [DATA_BITS-1:0] dataOut;
  logic                 dataValid, parityError, framingError;

  // Two-stage synchroniser plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= bus.RxIn;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  assign startEdge = rxPrev & ~rxSync;
  assign midTick   = tick && (tickCnt == MID_TICK);
  assign fullTick  = tick && (tickCnt == LAST_TICK);

  uart_rx_tick_gen #(.CLK_FREQ(CLK_FREQ)) tickGen (
    .Clock   (Clock),
    .Reset   (Reset),
    .baudSel (baudL),
    .restart (restart),
    .tick    (tick)
  );

  // FSM state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and per-cycle strobes.
  always_comb begin
    stateNext = state;
    restart   = 1'b0;
    frameDone = 1'b0;
    case (state)
      IDLE: begin
        if (startEdge) begin
          stateNext = START;
          restart   = 1'b1;
        end
      end
      START: begin
        // A line back high at mid start bit was a glitch, not a frame.
        if (midTick) stateNext = rxSync ? IDLE : DATA;
      end
      DATA: begin
        if (fullTick && bitCnt == LAST_BIT) stateNext = parityEnL ? PARITY : STOP;
      end
      PARITY: begin
        if (fullTick) stateNext = STOP;
      end
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (fullTick) begin
          stateNext = IDLE;
          frameDone = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Frame datapath: config latch, tick/bit counters, shifter, parity and outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      baudL        <= BAUD_2400;
      parityEnL    <= 1'b0;
      parityOddL   <= 1'b0;
      tickCnt      <= '0;
      bitCnt       <= '0;
      shiftReg     <= '0;
      parityErr    <= 1'b0;
      dataOut      <= '0;
      dataValid    <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
    end else begin
      dataValid <= 1'b0;

      if (restart) begin
        baudL      <= baudSel_t'(bus.BaudRate);
        parityEnL  <= bus.ParityEn;
        parityOddL <= bus.ParityOdd;
        tickCnt    <= '0;
        bitCnt     <= '0;
        parityErr  <= 1'b0;
      end else if (tick && state != IDLE) begin
        if (midTick && state == START) begin
          tickCnt <= '0;
        end else if (tickCnt == LAST_TICK) begin
          tickCnt <= '0;
        end else begin
          tickCnt <= tickCnt + 1'b1;
        end
      end

      if (state == DATA && fullTick) begin
        shiftReg <= {rxSync, shiftReg[DATA_BITS-1:1]};
        bitCnt   <= bitCnt + 1'b1;
      end

      if (state == PARITY && fullTick) begin
        parityErr <= ((^shiftReg) ^ rxSync) != parityOddL;
      end

      if (frameDone) begin
        dataOut      <= shiftReg;
        framingError <= ~rxSync;
        parityError  <= parityEnL & parityErr;
        dataValid    <= 1'b1;
      end
    end
  end

  assign bus.DataOut      = dataOut;
  assign bus.DataValid    = dataValid;
  assign bus.ParityError  = parityError;
  assign bus.FramingError = framingError;
  assign bus.Busy         = (state != IDLE);
  assign StateDbg         = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// each frame's expected byte and flags pushed to a queue and compared when
// DataValid pulses.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned TB_CLK     = 1_000_000;
  localparam int          MAX_CYCLES = 95_000;

  logic     clk;
  logic     rst;
  rxState_t stateDbg;

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(TB_CLK)) dut (
    .Clock    (clk),
    .Reset    (rst),
    .bus      (bus),
    .StateDbg (stateDbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    repeat (MAX_CYCLES) @(posedge clk);
    $display("FAIL watchdog: run exceeded %0d cycles", MAX_CYCLES);
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checkCount = 0;
  int errCount   = 0;
  int validCount = 0;
  logic prevValid = 1'b0;
  logic [7:0] lastData = 8'h00;
  logic [9:0] expQ[$];   // {framingError, parityError, data}

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned bauds[4] = '{2400, 4800, 9600, 19200};

  function automatic int divFor(input int sel);
    return $rtoi(real'(TB_CLK) / (real'(bauds[sel]) * 16.0) + 0.5);
  endfunction

  function automatic int bitCyclesFor(input int sel);
    return 16 * divFor(sel);
  endfunction

  // A frame's outcome: byte as sent, parity error when the count of ones in
  // data plus parity bit disagrees with the selected sense, framing error
  // when the stop bit is low.
  task automatic expectFrame(input logic [7:0] data, input logic parEn, input logic odd,
                             input logic pBit, input logic stopBit);
    int   ones;
    logic pe;
    ones = $countones(data) + int'(pBit);
    pe   = parEn && ((ones % 2) != int'(odd));
    expQ.push_back({~stopBit, pe, data});
  endtask

  // ---------------- driver ----------------
  task automatic driveBit(input logic v, input int n);
    bus.RxIn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic parEn, input logic pBit,
                           input logic stopBit, input int bitCycles);
    driveBit(1'b0, bitCycles);
    for (int i = 0; i < 8; i++) driveBit(data[i], bitCycles);
    if (parEn) driveBit(pBit, bitCycles);
    driveBit(stopBit, bitCycles);
  endtask

  task automatic sendChecked(input logic [7:0] data, input logic parEn, input logic odd,
                             input logic pBit, input logic stopBit, input int bitCycles);
    expectFrame(data, parEn, odd, pBit, stopBit);
    sendFrame(data, parEn, pBit, stopBit, bitCycles);
  endtask

  task automatic waitDrain(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkEq(tag, 32'(expQ.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst && bus.DataValid) begin
      validCount++;
      checkEq("valid_width", 32'(prevValid), 32'd0);
      checkEq("valid_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        lastData = e[7:0];
        checkEq("data", 32'(bus.DataOut), 32'(e[7:0]));
        checkEq("parity_err", 32'(bus.ParityError), 32'(e[8]));
        checkEq("framing_err", 32'(bus.FramingError), 32'(e[9]));
      end
    end
    prevValid = bus.DataValid;
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    int bc;
    logic [7:0] d;
    logic pe, po, pb, sb;
    int gap, sel;
    logic [15:0] defDiv;
    int defExp[4];

    rst           = 1'b1;
    bus.RxIn      = 1'b1;
    bus.BaudRate  = 2'b10;
    bus.ParityEn  = 1'b0;
    bus.ParityOdd = 1'b0;
    repeat (4) @(negedge clk);

    // Default-clock divisor constants.
    defExp = '{1302, 651, 326, 163};
    for (int i = 0; i < 4; i++) begin
      defDiv = baudDivisor(baudSel_t'(i), 50_000_000);
      checkEq("default_divisor", 32'(defDiv), 32'(defExp[i]));
    end

    // Reset values.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkEq("reset_data", 32'(bus.DataOut), 32'h00);
    checkEq("reset_valid", 32'(bus.DataValid), 32'd0);
    checkEq("reset_perr", 32'(bus.ParityError), 32'd0);
    checkEq("reset_ferr", 32'(bus.FramingError), 32'd0);
    checkEq("reset_busy", 32'(bus.Busy), 32'd0);
    checkEq("reset_state", 32'(stateDbg), 32'(IDLE));

    // 9600, no parity, 0xA5.
    bc = bitCyclesFor(2);
    v0 = validCount;
    sendChecked(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, bc);
    driveBit(1'b1, bc);
    waitDrain("drain_a5", 4 * bc);
    checkEq("a5_count", 32'(validCount - v0), 32'd1);

    // 19200, even parity, 0x3C with wrong then right parity bit.
    bus.BaudRate = 2'b11;
    bus.ParityEn = 1'b1;
    bus.ParityOdd = 1'b0;
    bc = bitCyclesFor(3);
    sendChecked(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, bc);
    driveBit(1'b1, 2 * bc);
    waitDrain("drain_par_bad", 4 * bc);
    checkEq("perr_hold", 32'(bus.ParityError), 32'd1);
    sendChecked(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, bc);
    driveBit(1'b1, bc);
    waitDrain("drain_par_ok", 4 * bc);

    // 2400, 0x55 with bad stop bit, then a 20-bit break.
    bus.BaudRate = 2'b00;
    bus.ParityEn = 1'b0;
    bc = bitCyclesFor(0);
    sendChecked(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, bc);
    driveBit(1'b1, 2 * bc);
    waitDrain("drain_stop0", 4 * bc);
    v0 = validCount;
    expQ.push_back({1'b1, 1'b0, 8'h00});
    driveBit(1'b0, 20 * bc);
    checkEq("break_once", 32'(validCount - v0), 32'd1);
    checkEq("break_data_hold", 32'(bus.DataOut), 32'h00);
    checkEq("break_ferr_hold", 32'(bus.FramingError), 32'd1);
    checkEq("break_idle", 32'(bus.Busy), 32'd0);
    driveBit(1'b1, 2 * bc);
    checkEq("break_after_rise", 32'(validCount - v0), 32'd1);
    waitDrain("drain_break", 4);

    // Glitch at 9600: low for less than half a bit.
    bus.BaudRate = 2'b10;
    v0 = validCount;
    driveBit(1'b0, 5 * divFor(2) + 5);
    driveBit(1'b1, 8 * divFor(2) - (5 * divFor(2) + 5) - 8);
    checkEq("glitch_busy", 32'(bus.Busy), 32'd1);
    driveBit(1'b1, 28);
    checkEq("glitch_busy_clear", 32'(bus.Busy), 32'd0);
    checkEq("glitch_no_valid", 32'(validCount - v0), 32'd0);
    checkEq("glitch_data_hold", 32'(bus.DataOut), 32'(lastData));

    // Baud and parity change mid-frame: frame keeps its latched settings.
    bc = bitCyclesFor(2);
    expectFrame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    fork
      sendFrame(8'hC3, 1'b0, 1'b0, 1'b1, bc);
      begin
        repeat (3 * bc) @(negedge clk);
        bus.BaudRate = 2'b11;
        bus.ParityEn = 1'b1;
      end
    join
    driveBit(1'b1, bc);
    waitDrain("drain_c3", 4 * bc);
    bc = bitCyclesFor(3);
    sendChecked(8'h5E, 1'b1, 1'b0, ^8'h5E, 1'b1, bc);
    driveBit(1'b1, bc);
    waitDrain("drain_5e", 4 * bc);

    // Reset during bit 4 of a frame (0x5A, bit 4 high).
    bus.ParityEn = 1'b0;
    v0 = validCount;
    driveBit(1'b0, bc);
    for (int i = 0; i < 4; i++) driveBit(1'(8'h5A >> i), bc);
    driveBit(1'b1, bc / 2);
    checkEq("midframe_busy", 32'(bus.Busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkEq("rst_data", 32'(bus.DataOut), 32'h00);
    checkEq("rst_valid", 32'(bus.DataValid), 32'd0);
    checkEq("rst_perr", 32'(bus.ParityError), 32'd0);
    checkEq("rst_ferr", 32'(bus.FramingError), 32'd0);
    checkEq("rst_busy", 32'(bus.Busy), 32'd0);
    lastData = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    driveBit(1'b1, 3 * bc);
    checkEq("rst_no_valid", 32'(validCount - v0), 32'd0);
    sendChecked(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, bc);
    driveBit(1'b1, bc);
    waitDrain("drain_81", 4 * bc);

    // Random frames: baud, parity, data, parity bit, stop bit and gap.
    for (int n = 0; n < 16; n++) begin
      sel = $urandom_range(1, 3);
      d   = 8'($urandom_range(0, 255));
      pe  = 1'($urandom_range(0, 1));
      po  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 7) != 0);
      gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
      bus.BaudRate  = 2'(sel);
      bus.ParityEn  = pe;
      bus.ParityOdd = po;
      bc = bitCyclesFor(sel);
      sendChecked(d, pe, po, pb, sb, bc);
      if (gap > 0) driveBit(1'b1, gap * bc);
    end
    driveBit(1'b1, bitCyclesFor(1));
    waitDrain("drain_random", 4 * bitCyclesFor(1));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
